c16_prg_loader: RTL and testbench
=================================

// Module: c16_prg_loader
// PURPOSE
//  Injects a host-supplied .PRG image into C16 RAM. Sits upstream of the C16 core,
//  muxed onto its RAM port. Holds the CPU via WAIT, strips the 2-byte little-endian
//  load header and writes the payload sequentially. Then patches the BASIC end
//  pointers ($2D-$32) so that RUN and LIST work.
// PARAMETERS
//  STALL_CYC  16  clocks WAIT is held before the first RAM write (CPU reaches a cycle boundary)
//  WR_CYC     4   clocks RAM_WE is held per byte write (>=1)
//  PTR_FIX    1   1: write end address to $2D/$2E,$2F/$30,$31/$32 after the payload; 0: skip
// PORTS
//  CLK28      in   1   system clock, 28 MHz
//  RESET_N    in   1   asynchronous active-low reset
//  DL_ACTIVE  in   1   high for the whole download
//  DL_WR      in   1   one-clock strobe: DL_DATA valid
//  DL_DATA    in   8   file byte
//  DL_BUSY    out  1   high while a byte is being processed; host must not strobe
//  WAIT       out  1   to C16 WAIT input; freezes the CPU
//  RAM_WE     out  1   RAM write enable; the mux selects the loader when WAIT=1
//  RAM_ADDR   out  16  RAM write address
//  RAM_DOUT   out  8   RAM write data
//  DONE       out  1   one-clock pulse on successful completion
//  ERR        out  1   sticky; set on short file, overrun or truncation; cleared on next DL_ACTIVE rise
// BEHAVIOUR
//  - Reset: all outputs 0. State=IDLE. Internal addr/count=0.
//  - FSM IDLE->STALL on a DL_ACTIVE rising edge.
//    On that edge: WAIT=1 (next clock), ERR cleared, DL_BUSY=1.
//  - STALL: count STALL_CYC clocks, then DL_BUSY=0 and go to HDR_LO.
//  - HDR_LO: on DL_WR, latch addr[7:0], go to HDR_HI.
//    HDR_HI: on DL_WR, latch addr[15:8], go to DATA.
//    No RAM write occurs for header bytes. DL_BUSY stays 0.
//  - DATA: on DL_WR, RAM_ADDR=addr and RAM_DOUT=DL_DATA.
//    RAM_WE=1 and DL_BUSY=1 for exactly WR_CYC clocks (WRITE state), from the clock after the strobe.
//    Then addr+=1, DL_BUSY=0, return to DATA.
//    Latency from strobe to WE: 1 clock.
//  - Wrap: a write at addr=$FFFF is performed. A flag `wrapped` is then set.
//    Further bytes are accepted but not written (RAM_WE stays 0) and set ERR.
//    The end pointer is $0000 (16-bit wrap).
//  - DL_WR while DL_BUSY=1 (overrun): the byte is dropped, ERR=1, and the FSM is unaffected.
//  - DL_ACTIVE falls:
//      in STALL/HDR_LO/HDR_HI (fewer than 2 header bytes, or header only) -> ERR=1, go to FINISH, no pointer fix.
//      in DATA -> go to PTR if PTR_FIX=1 and at least 1 payload byte was written, else FINISH.
//      in WRITE -> complete the current write first, then apply the DATA rule.
//  - PTR: 6 writes in order $2D=end[7:0], $2E=end[15:8], $2F, $30, $31, $32 (same pair repeated).
//    Each write takes WR_CYC clocks. end = addr after the last payload byte (load addr + payload length, mod 2^16).
//  - FINISH: one clock. WAIT=0, RAM_WE=0. DONE=1 for that clock only if ERR=0.
//    Then IDLE. DL_BUSY=0 in IDLE.
//  - A new DL_ACTIVE rise is ignored unless the FSM is in IDLE.
//  - Async reset mid-operation: immediate return to IDLE. WAIT and RAM_WE drop asynchronously.
//    The partial image remains in RAM and no DONE is produced.
//  - RAM_ADDR/RAM_DOUT hold their last value when RAM_WE=0.
// TESTING
//  1. File 01 10 AA BB CC, WR_CYC=4 -> WAIT high; writes $1001=AA, $1002=BB, $1003=CC, 4 clocks each.
//     Then $2D=04,$2E=10,$2F=04,$30=10,$31=04,$32=10; DONE pulse; WAIT low; ERR=0.
//  2. Header FE FF, data 11 22 33 -> $FFFE=11, $FFFF=22; 33 not written; ERR=1;
//     pointers $2D..$32 = 00,00 x3; no DONE.
//  3. DL_ACTIVE drops after a single byte 01 -> no RAM_WE ever; ERR=1; WAIT released in FINISH; no DONE.
//  4. DL_WR on the clock after a data strobe (during WRITE) -> byte dropped; the first write completes intact; ERR=1.
//  5. RESET_N low during the PTR state -> WAIT and RAM_WE go to 0 without a clock edge; FSM in IDLE;
//     a fresh download afterwards completes with DONE.
//  6. PTR_FIX=0, file 00 30 55 -> only $3000=55 written; no writes to $2D-$32; DONE pulse.

Source files
------------

// File: rtl/c16_prg_loader.sv
// c16_prg_loader: loads a host-supplied .PRG image into C16 RAM.
// The CPU is frozen through WAIT while the loader owns the RAM port.
// The 2-byte little-endian load address is stripped off, and the payload
// is written sequentially from that address. Afterwards the BASIC end
// pointers $2D-$32 are optionally patched so that RUN and LIST work.
// STALL_CYC and WR_CYC must both be at least 1.
module c16_prg_loader #(
    parameter int unsigned STALL_CYC = 16,
    parameter int unsigned WR_CYC    = 4,
    parameter bit          PTR_FIX   = 1'b1
) (
    input  logic        CLK28,
    input  logic        RESET_N,
    input  logic        DL_ACTIVE,
    input  logic        DL_WR,
    input  logic [7:0]  DL_DATA,
    output logic        DL_BUSY,
    output logic        WAIT,
    output logic        RAM_WE,
    output logic [15:0] RAM_ADDR,
    output logic [7:0]  RAM_DOUT,
    output logic        DONE,
    output logic        ERR
);

    typedef enum logic [2:0] {
        IDLE, STALL, HDR_LO, HDR_HI, DATA, WRITE, PTR, FINISH
    } state_t;

    state_t      state, state_n;
    logic [15:0] cnt;          // clocks spent in the current state / pointer byte
    logic [15:0] addr;         // next payload address; the end pointer afterwards
    logic [2:0]  ptr_idx;      // which of the six pointer bytes is being written
    logic        wrapped;      // a byte has been written at $FFFF
    logic        wrote_any;    // at least one payload byte reached RAM
    logic        err;
    logic        dl_active_q;

    logic dl_rise, stall_last, wr_last;
    logic start_dl, set_err, ld_lo, ld_hi, ld_wr, wr_done, ptr_start, ptr_step;

    assign dl_rise    = DL_ACTIVE && !dl_active_q;
    assign stall_last = (cnt == 16'(STALL_CYC - 1));
    assign wr_last    = (cnt == 16'(WR_CYC - 1));

    // Outputs are decoded from the registered state, so an asynchronous
    // reset drops WAIT and RAM_WE at once, without waiting for a clock.
    assign WAIT    = (state != IDLE) && (state != FINISH);
    assign RAM_WE  = (state == WRITE) || (state == PTR);
    assign DL_BUSY = (state == STALL) || (state == WRITE) || (state == PTR);
    assign DONE    = (state == FINISH) && !err;
    assign ERR     = err;

    // State register.
    // NOTE: sequential state uses non-blocking (<=) assignments so that every
    // register samples the values from before the edge; blocking (=) here
    // would make the result depend on statement order.
    always_ff @(posedge CLK28 or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_n;
    end

    // Next-state decode and the datapath strobes that go with each transition.
    always_comb begin
        // NOTE: every signal gets a default before the case statement; a path
        // that left one unassigned would infer a latch.
        state_n   = state;
        start_dl  = 1'b0;
        set_err   = DL_WR && DL_BUSY;   // overrun: byte dropped, FSM untouched
        ld_lo     = 1'b0;
        ld_hi     = 1'b0;
        ld_wr     = 1'b0;
        wr_done   = 1'b0;
        ptr_start = 1'b0;
        ptr_step  = 1'b0;
        unique case (state)
            IDLE: if (dl_rise) begin
                state_n  = STALL;
                start_dl = 1'b1;
            end
            STALL: if (!DL_ACTIVE) begin
                set_err = 1'b1;
                state_n = FINISH;
            end else if (stall_last) begin
                state_n = HDR_LO;
            end
            HDR_LO: if (!DL_ACTIVE) begin
                set_err = 1'b1;
                state_n = FINISH;
            end else if (DL_WR) begin
                ld_lo   = 1'b1;
                state_n = HDR_HI;
            end
            HDR_HI: if (!DL_ACTIVE) begin
                set_err = 1'b1;
                state_n = FINISH;
            end else if (DL_WR) begin
                ld_hi   = 1'b1;
                state_n = DATA;
            end
            DATA: if (!DL_ACTIVE) begin
                if (PTR_FIX && wrote_any) begin
                    ptr_start = 1'b1;
                    state_n   = PTR;
                end else begin
                    state_n = FINISH;
                end
            end else if (DL_WR) begin
                if (wrapped) begin
                    set_err = 1'b1;     // past $FFFF: accepted, never written
                end else begin
                    ld_wr   = 1'b1;
                    state_n = WRITE;
                end
            end
            WRITE: if (wr_last) begin
                wr_done = 1'b1;
                state_n = DATA;         // DATA re-checks DL_ACTIVE next clock
            end
            PTR: if (wr_last) begin
                if (ptr_idx == 3'd5) state_n  = FINISH;
                else                 ptr_step = 1'b1;
            end
            FINISH: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Counters, load address, error flag and the RAM address/data registers.
    always_ff @(posedge CLK28 or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt         <= '0;
            addr        <= '0;
            ptr_idx     <= '0;
            wrapped     <= 1'b0;
            wrote_any   <= 1'b0;
            err         <= 1'b0;
            dl_active_q <= 1'b0;
            RAM_ADDR    <= '0;
            RAM_DOUT    <= '0;
        end else begin
            dl_active_q <= DL_ACTIVE;

            if (state_n != state || ptr_step) cnt <= '0;
            else                              cnt <= cnt + 16'd1;

            if (start_dl) begin
                err       <= 1'b0;
                addr      <= '0;
                wrapped   <= 1'b0;
                wrote_any <= 1'b0;
            end else if (set_err) begin
                err <= 1'b1;
            end

            if (ld_lo) addr[7:0]  <= DL_DATA;
            if (ld_hi) addr[15:8] <= DL_DATA;

            if (ld_wr) begin
                RAM_ADDR <= addr;
                RAM_DOUT <= DL_DATA;
            end

            if (wr_done) begin
                addr      <= addr + 16'd1;   // $FFFF + 1 wraps to $0000
                wrote_any <= 1'b1;
                if (addr == 16'hFFFF) wrapped <= 1'b1;
            end

            // Pointer bytes alternate low/high of the end address at $2D..$32.
            if (ptr_start) begin
                ptr_idx  <= '0;
                RAM_ADDR <= 16'h002D;
                RAM_DOUT <= addr[7:0];
            end
            if (ptr_step) begin
                ptr_idx  <= ptr_idx + 3'd1;
                RAM_ADDR <= RAM_ADDR + 16'd1;
                RAM_DOUT <= ptr_idx[0] ? addr[7:0] : addr[15:8];
            end
        end
    end

endmodule

// File: tb/tb_c16_prg_loader.sv
// tb_c16_prg_loader: directed bench for the .PRG loader. Two instances are
// used: u_dut0 with pointer patching enabled, u_dut1 with it disabled. They
// share the strobe/data lines but have separate DL_ACTIVE inputs. Every RAM
// write is logged as (address, data, clocks WE was held) and compared against
// hand-computed expectations.
module tb_c16_prg_loader;

    localparam int WRC = 4;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        int          n;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        act0 = 1'b0, act1 = 1'b0;
    logic        dl_wr = 1'b0;
    logic [7:0]  dl_data = 8'h00;

    logic        busy0, wait0, we0, done0, err0;
    logic [15:0] addr0;
    logic [7:0]  dout0;
    logic        busy1, wait1, we1, done1, err1;
    logic [15:0] addr1;
    logic [7:0]  dout1;

    int  n_tests = 0;
    int  n_fail  = 0;
    int  done0_cnt = 0, done1_cnt = 0;
    logic we0_prev = 1'b0, we1_prev = 1'b0;
    wr_t log0[$];
    wr_t log1[$];
    wr_t exp_q[$];

    always #5 clk = ~clk;

    c16_prg_loader #(.STALL_CYC(16), .WR_CYC(WRC), .PTR_FIX(1'b1)) u_dut0 (
        .CLK28(clk), .RESET_N(rst_n), .DL_ACTIVE(act0), .DL_WR(dl_wr), .DL_DATA(dl_data),
        .DL_BUSY(busy0), .WAIT(wait0), .RAM_WE(we0), .RAM_ADDR(addr0), .RAM_DOUT(dout0),
        .DONE(done0), .ERR(err0)
    );

    c16_prg_loader #(.STALL_CYC(16), .WR_CYC(WRC), .PTR_FIX(1'b0)) u_dut1 (
        .CLK28(clk), .RESET_N(rst_n), .DL_ACTIVE(act1), .DL_WR(dl_wr), .DL_DATA(dl_data),
        .DL_BUSY(busy1), .WAIT(wait1), .RAM_WE(we1), .RAM_ADDR(addr1), .RAM_DOUT(dout1),
        .DONE(done1), .ERR(err1)
    );

    // Write/DONE monitors, sampled on the falling edge.
    always @(negedge clk) begin
        wr_t e;
        if (we0) begin
            if (we0_prev && log0.size() > 0 && log0[log0.size()-1].a == addr0
                && log0[log0.size()-1].d == dout0) begin
                e = log0[log0.size()-1];
                e.n = e.n + 1;
                log0[log0.size()-1] = e;
            end else begin
                e.a = addr0; e.d = dout0; e.n = 1;
                log0.push_back(e);
            end
        end
        we0_prev = we0;
        if (we1) begin
            if (we1_prev && log1.size() > 0 && log1[log1.size()-1].a == addr1
                && log1[log1.size()-1].d == dout1) begin
                e = log1[log1.size()-1];
                e.n = e.n + 1;
                log1[log1.size()-1] = e;
            end else begin
                e.a = addr1; e.d = dout1; e.n = 1;
                log1.push_back(e);
            end
        end
        we1_prev = we1;
        if (done0) done0_cnt++;
        if (done1) done1_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        log0.delete();
        log1.delete();
        exp_q.delete();
        done0_cnt = 0;
        done1_cnt = 0;
    endtask

    task automatic exp_wr(input logic [15:0] a, input logic [7:0] d);
        wr_t e;
        e.a = a; e.d = d; e.n = WRC;
        exp_q.push_back(e);
    endtask

    task automatic exp_ptr(input logic [15:0] endp);
        for (int i = 0; i < 6; i++)
            exp_wr(16'h002D + 16'(i), (i % 2 == 1) ? endp[15:8] : endp[7:0]);
    endtask

    task automatic check_log(input string t, input int sel);
        wr_t g[$];
        if (sel == 0) g = log0;
        else          g = log1;
        check({t, "_nwr"}, 32'(g.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < g.size(); i++) begin
            check($sformatf("%s_w%0d_addr", t, i), 32'(g[i].a), 32'(exp_q[i].a));
            check($sformatf("%s_w%0d_data", t, i), 32'(g[i].d), 32'(exp_q[i].d));
            check($sformatf("%s_w%0d_len", t, i), 32'(g[i].n), 32'(exp_q[i].n));
        end
    endtask

    // Raise DL_ACTIVE at a falling edge; expect WAIT one clock later and a
    // STALL of exactly 16 clocks with DL_BUSY high.
    task automatic start_dl(input int sel, input string t);
        int n = 0;
        if (sel == 0) act0 = 1'b1;
        else          act1 = 1'b1;
        @(negedge clk);
        check({t, "_wait_hi"}, 32'((sel != 0) ? wait1 : wait0), 32'd1);
        while ((busy0 || busy1) && n < 200) begin
            n++;
            @(negedge clk);
        end
        check({t, "_stall_len"}, 32'(n), 32'd16);
    endtask

    // One-clock DL_WR strobe once the loader is not busy; optionally confirm
    // RAM_WE one clock after the strobe.
    task automatic send_byte(input logic [7:0] b, input bit chk_we, input string t);
        int n = 0;
        while ((busy0 || busy1) && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) check({t, "_busy_timeout"}, 32'd1, 32'd0);
        dl_wr   = 1'b1;
        dl_data = b;
        @(negedge clk);
        dl_wr = 1'b0;
        if (chk_we) check({t, "_we_latency"}, 32'(we0 | we1), 32'd1);
    endtask

    task automatic drop_dl(input int sel);
        if (sel == 0) act0 = 1'b0;
        else          act1 = 1'b0;
        repeat (60) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;

        // Reset state.
        #12;
        check("rst_outputs", {7'd0, busy0, wait0, we0, done0, err0, addr0, dout0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: basic load at $1001 with pointer patch.
        clear_logs();
        start_dl(0, "t1");
        send_byte(8'h01, 1'b0, "t1_hlo");
        send_byte(8'h10, 1'b0, "t1_hhi");
        check("t1_no_hdr_write", 32'(log0.size()), 32'd0);
        send_byte(8'hAA, 1'b1, "t1_d0");
        send_byte(8'hBB, 1'b1, "t1_d1");
        send_byte(8'hCC, 1'b1, "t1_d2");
        drop_dl(0);
        exp_wr(16'h1001, 8'hAA);
        exp_wr(16'h1002, 8'hBB);
        exp_wr(16'h1003, 8'hCC);
        exp_ptr(16'h1004);
        check_log("t1", 0);
        check("t1_err", 32'(err0), 32'd0);
        check("t1_done", 32'(done0_cnt), 32'd1);
        check("t1_wait_lo", 32'(wait0), 32'd0);

        // 2: wrap past $FFFF.
        clear_logs();
        start_dl(0, "t2");
        send_byte(8'hFE, 1'b0, "t2_hlo");
        send_byte(8'hFF, 1'b0, "t2_hhi");
        send_byte(8'h11, 1'b1, "t2_d0");
        send_byte(8'h22, 1'b1, "t2_d1");
        send_byte(8'h33, 1'b0, "t2_d2");
        drop_dl(0);
        exp_wr(16'hFFFE, 8'h11);
        exp_wr(16'hFFFF, 8'h22);
        exp_ptr(16'h0000);
        check_log("t2", 0);
        check("t2_err", 32'(err0), 32'd1);
        check("t2_done", 32'(done0_cnt), 32'd0);
        check("t2_wait_lo", 32'(wait0), 32'd0);

        // 3: short file, a single header byte.
        clear_logs();
        start_dl(0, "t3");
        send_byte(8'h01, 1'b0, "t3_hlo");
        drop_dl(0);
        check_log("t3", 0);
        check("t3_err", 32'(err0), 32'd1);
        check("t3_done", 32'(done0_cnt), 32'd0);
        check("t3_wait_lo", 32'(wait0), 32'd0);

        // 4: overrun strobe on the clock after a data strobe.
        clear_logs();
        start_dl(0, "t4");
        send_byte(8'h00, 1'b0, "t4_hlo");
        send_byte(8'h20, 1'b0, "t4_hhi");
        dl_wr = 1'b1;
        dl_data = 8'h5A;
        @(negedge clk);
        dl_data = 8'h77;
        @(negedge clk);
        dl_wr = 1'b0;
        drop_dl(0);
        exp_wr(16'h2000, 8'h5A);
        exp_ptr(16'h2001);
        check_log("t4", 0);
        check("t4_err", 32'(err0), 32'd1);
        check("t4_done", 32'(done0_cnt), 32'd0);

        // 5: asynchronous reset in the pointer phase, then a fresh load.
        clear_logs();
        start_dl(0, "t5");
        send_byte(8'h00, 1'b0, "t5_hlo");
        send_byte(8'h40, 1'b0, "t5_hhi");
        send_byte(8'h99, 1'b1, "t5_d0");
        act0 = 1'b0;
        n = 0;
        while (!(we0 && addr0 == 16'h002F) && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("t5_reach_ptr", 32'(n < 200), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_wait", 32'(wait0), 32'd0);
        check("t5_rst_we", 32'(we0), 32'd0);
        check("t5_rst_busy", 32'(busy0), 32'd0);
        check("t5_rst_nodone", 32'(done0_cnt), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        clear_logs();
        start_dl(0, "t5b");
        send_byte(8'h10, 1'b0, "t5b_hlo");
        send_byte(8'h50, 1'b0, "t5b_hhi");
        send_byte(8'h42, 1'b1, "t5b_d0");
        drop_dl(0);
        exp_wr(16'h5010, 8'h42);
        exp_ptr(16'h5011);
        check_log("t5b", 0);
        check("t5b_err", 32'(err0), 32'd0);
        check("t5b_done", 32'(done0_cnt), 32'd1);

        // 6: pointer patch disabled.
        clear_logs();
        start_dl(1, "t6");
        send_byte(8'h00, 1'b0, "t6_hlo");
        send_byte(8'h30, 1'b0, "t6_hhi");
        send_byte(8'h55, 1'b1, "t6_d0");
        drop_dl(1);
        exp_wr(16'h3000, 8'h55);
        check_log("t6", 1);
        check("t6_err", 32'(err1), 32'd0);
        check("t6_done", 32'(done1_cnt), 32'd1);
        check("t6_wait_lo", 32'(wait1), 32'd0);
        check("t6_dut0_idle", 32'(log0.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
